// File: rtl/fpm_ctrl_pkg.sv
// Shared definitions for the fp multiplier sequencing controller: state encoding,
// watchdog defaults and the wait-timer width helper.
package fpm_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_EXP    = 3'd1;
  localparam logic [2:0] ST_BIAS   = 3'd2;
  localparam logic [2:0] ST_MSTART = 3'd3;
  localparam logic [2:0] ST_MWAIT  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ZDONE  = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_EXP    = ST_EXP,
    S_BIAS   = ST_BIAS,
    S_MSTART = ST_MSTART,
    S_MWAIT  = ST_MWAIT,
    S_DONE   = ST_DONE,
    S_ZDONE  = ST_ZDONE,
    S_ERR    = ST_ERR
  } state_t;

  localparam int DEFAULT_MAX_WAIT = 64;
  localparam int DEFAULT_WAIT_W   = $clog2(DEFAULT_MAX_WAIT + 1);

  function automatic int wait_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/fpm_wait_timer.sv
// Loadable down-counter for the multiply-wait watchdog; expired is high during
// the final permitted cycle, so the caller can leave on that edge.
module fpm_wait_timer #(
  parameter int W    = 7,
  parameter int LOAD = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(LOAD);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequencer driving the fp multiplier datapath enables: capture, exponent, bias, start, wait, complete.
// Define FPM_CTRL_WATCHDOG_EN to bound the multiply wait with a sticky timeout_err.
module fp_mul_seq_ctrl
  import fpm_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_zero,
  input  logic             mul_done,
  output logic             reg_1_e,
  output logic             reg_2_e,
  output logic             rwe_a,
  output logic             rwe_b,
  output logic             mul_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_zero,
  output logic             timeout_err,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  state_t state, next_state;
  logic   accept;
  logic   wd_expired;

  assign accept = (state == S_IDLE) && in_valid && in_ready;
  assign busy   = (state != S_IDLE);

`ifdef FPM_CTRL_WATCHDOG_EN
  localparam int WAIT_W = wait_width(MAX_WAIT);

  // Loaded while MSTART so the count starts fresh on the first MWAIT cycle.
  fpm_wait_timer #(
    .W    (WAIT_W),
    .LOAD (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (state == S_MSTART),
    .en      (state == S_MWAIT),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if ((state == S_MWAIT) && (next_state == S_ERR)) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    next_state = state;
    reg_1_e    = 1'b0;
    reg_2_e    = 1'b0;
    rwe_a      = 1'b0;
    rwe_b      = 1'b0;
    mul_enable = 1'b0;
    out_valid  = 1'b0;
    out_zero   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          reg_1_e    = 1'b1;
          reg_2_e    = 1'b1;
          next_state = S_EXP;
        end
      end
      S_EXP: begin
        rwe_a      = 1'b1;
        next_state = is_zero ? S_ZDONE : S_BIAS;
      end
      S_BIAS: begin
        rwe_b      = 1'b1;
        next_state = S_MSTART;
      end
      // mul_done may still be high from the previous op here, so it is not looked at.
      S_MSTART: begin
        mul_enable = 1'b1;
        next_state = S_MWAIT;
      end
      S_MWAIT: begin
        if (mul_done) begin
          next_state = S_DONE;
        end else if (wd_expired) begin
          next_state = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      S_ZDONE: begin
        out_valid = 1'b1;
        out_zero  = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      op_count <= '0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == S_IDLE);
      if (((state == S_DONE) || (state == S_ZDONE)) && out_ready) begin
        op_count <= op_count + CNT_W'(1);
      end
    end
  end

endmodule
